video_timing_gen: RTL

Parametrised raster timing generator that replaces fixed-count sync generators in arcade cores. It produces H/V counters, blanking, syncs, display enable, line/frame strobes and an interlace field flag. Counting advances on a pixel clock enable, and sync position is adjustable at runtime for screen centring. It sits between the system clock domain and the video mixer / scandoubler.

---
 rtl/video_timing_gen_if.sv | 25 ++
 rtl/video_timing_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle driven by video_timing_gen toward the mixer / scandoubler.
interface video_timing_gen_if #(
    parameter int CNT_W = 9
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hb;
    logic             vb;
    logic             de;
    logic             hs;
    logic             vs;
    logic             line_start;
    logic             frame;
    logic             field;

    // Every signal is a registered level from the generator with no back-pressure;
    // line_start and frame are one-clk strobes the consumer must catch on that clk.
    modport master (
        output hcount, vcount, hb, vb, de, hs, vs, line_start, frame, field
    );

    modport slave (
        input hcount, vcount, hb, vb, de, hs, vs, line_start, frame, field
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, blanking, adjustable syncs,
// line/frame strobes and interlace field flag, all advancing on ce_pix.
module video_timing_gen #(
    parameter int CNT_W        = 9,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 274,
    parameter int H_SYNC_END   = 299,
    parameter int H_TOTAL      = 443,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 242,
    parameter int V_SYNC_END   = 245,
    parameter int V_TOTAL      = 263,
    parameter int HS_POL       = 0,
    parameter int VS_POL       = 0,
    parameter int INTERLACE    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce_pix,
    input  logic signed [3:0]         h_adj,
    input  logic signed [3:0]         v_adj,
    video_timing_gen_if.master        vid
);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_EVEN = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_ODD  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_ACT       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT       = CNT_W'(V_ACTIVE);

    localparam logic signed [CNT_W:0] HS_LO = (CNT_W+1)'(H_ACTIVE);
    localparam logic signed [CNT_W:0] HS_HI = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic signed [CNT_W:0] HSS_X = (CNT_W+1)'(H_SYNC_START);
    localparam logic signed [CNT_W:0] HSE_X = (CNT_W+1)'(H_SYNC_END);
    localparam logic signed [CNT_W:0] VS_LO = (CNT_W+1)'(V_ACTIVE);
    localparam logic signed [CNT_W:0] VS_HI = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic signed [CNT_W:0] VSS_X = (CNT_W+1)'(V_SYNC_START);
    localparam logic signed [CNT_W:0] VSE_X = (CNT_W+1)'(V_SYNC_END);

    localparam logic HS_IDLE = (HS_POL != 0) ? 1'b0 : 1'b1;
    localparam logic VS_IDLE = (VS_POL != 0) ? 1'b0 : 1'b1;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             field_q, field_d;
    logic             hb_q, hb_d;
    logic             vb_q, vb_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q;
    logic             frame_q;
    logic [3:0]       h_adj_q;
    logic [3:0]       v_adj_q;

    logic                    h_last, v_last, frame_wrap;
    logic                    hs_act, vs_act;
    logic signed [CNT_W:0]   h_adj_x, v_adj_x;
    logic [CNT_W:0]          hs0, hs1, vs0, vs1;

    // Clamp keeps sync windows inside the blanking interval whatever the adjust.
    function automatic logic [CNT_W:0] clamp_pos(input logic signed [CNT_W:0] x,
                                                 input logic signed [CNT_W:0] lo,
                                                 input logic signed [CNT_W:0] hi);
        logic signed [CNT_W:0] r;
        r = x;
        if (x < lo) r = lo;
        else if (x > hi) r = hi;
        return r;
    endfunction

    assign h_adj_x = {{(CNT_W-3){h_adj_q[3]}}, h_adj_q};
    assign v_adj_x = {{(CNT_W-3){v_adj_q[3]}}, v_adj_q};

    always_comb begin
        h_last     = (hcnt_q == H_LAST);
        v_last     = ((INTERLACE != 0) && field_q) ? (vcnt_q == V_LAST_ODD)
                                                   : (vcnt_q == V_LAST_EVEN);
        frame_wrap = h_last && v_last;

        hcnt_d = h_last ? '0 : hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        if (h_last) vcnt_d = v_last ? '0 : vcnt_q + CNT_W'(1);
        field_d = field_q;
        if (frame_wrap && (INTERLACE != 0)) field_d = ~field_q;

        hs0 = clamp_pos(HSS_X + h_adj_x, HS_LO, HS_HI);
        hs1 = clamp_pos(HSE_X + h_adj_x, HS_LO, HS_HI);
        vs0 = clamp_pos(VSS_X + v_adj_x, VS_LO, VS_HI);
        vs1 = clamp_pos(VSE_X + v_adj_x, VS_LO, VS_HI);

        // Decodes use the next counter values so they line up with hcount/vcount.
        hs_act = ({1'b0, hcnt_d} >= hs0) && ({1'b0, hcnt_d} < hs1);
        vs_act = ({1'b0, vcnt_d} >= vs0) && ({1'b0, vcnt_d} < vs1);
        hs_d   = (HS_POL != 0) ? hs_act : ~hs_act;
        vs_d   = (VS_POL != 0) ? vs_act : ~vs_act;
        hb_d   = (hcnt_d >= H_ACT);
        vb_d   = (vcnt_d >= V_ACT);
        de_d   = ~hb_d & ~vb_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            field_q <= 1'b0;
            hb_q    <= 1'b0;
            vb_q    <= 1'b0;
            de_q    <= 1'b1;
            hs_q    <= HS_IDLE;
            vs_q    <= VS_IDLE;
            ls_q    <= 1'b0;
            frame_q <= 1'b0;
            h_adj_q <= '0;
            v_adj_q <= '0;
        end else begin
            ls_q    <= ce_pix & h_last;
            frame_q <= ce_pix & frame_wrap;
            if (ce_pix) begin
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                field_q <= field_d;
                hb_q    <= hb_d;
                vb_q    <= vb_d;
                de_q    <= de_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                // Adjusts only change at frame start so no runt sync is produced.
                if (frame_wrap) begin
                    h_adj_q <= h_adj;
                    v_adj_q <= v_adj;
                end
            end
        end
    end

    assign vid.hcount     = hcnt_q;
    assign vid.vcount     = vcnt_q;
    assign vid.hb         = hb_q;
    assign vid.vb         = vb_q;
    assign vid.de         = de_q;
    assign vid.hs         = hs_q;
    assign vid.vs         = vs_q;
    assign vid.line_start = ls_q;
    assign vid.frame      = frame_q;
    assign vid.field      = field_q;
endmodule
